// File: rtl/xbar_out_arbiter_pkg.sv
// Shared router definitions: port indices, crossbar mux select encodings and
// the output-arbiter FSM state type, plus small port-index helpers.
package xbar_out_arbiter_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_SEL_W = 3;

  localparam logic [2:0] PORT_N = 3'd0;
  localparam logic [2:0] PORT_E = 3'd1;
  localparam logic [2:0] PORT_S = 3'd2;
  localparam logic [2:0] PORT_W = 3'd3;
  localparam logic [2:0] PORT_L = 3'd4;

  localparam logic [2:0] SEL_A = 3'b000;
  localparam logic [2:0] SEL_B = 3'b001;
  localparam logic [2:0] SEL_C = 3'b010;
  localparam logic [2:0] SEL_D = 3'b011;
  localparam logic [2:0] SEL_E = 3'b100;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [2:0] port_sel(input logic [2:0] port);
    logic [2:0] s;
    case (port)
      PORT_N:  s = SEL_A;
      PORT_E:  s = SEL_B;
      PORT_S:  s = SEL_C;
      PORT_W:  s = SEL_D;
      PORT_L:  s = SEL_E;
      default: s = SEL_A;
    endcase
    return s;
  endfunction

  function automatic logic [4:0] port_onehot(input logic [2:0] port);
    logic [4:0] oh;
    case (port)
      PORT_N:  oh = 5'b00001;
      PORT_E:  oh = 5'b00010;
      PORT_S:  oh = 5'b00100;
      PORT_W:  oh = 5'b01000;
      PORT_L:  oh = 5'b10000;
      default: oh = 5'b00000;
    endcase
    return oh;
  endfunction

  // Successor in the 0..4 ring; out-of-range values fold back to 0.
  function automatic logic [2:0] port_next(input logic [2:0] port);
    return (port >= PORT_L) ? PORT_N : port + 3'd1;
  endfunction

endpackage

// File: rtl/xbar_out_arbiter_rr_pick5.sv
// Combinational rotating-priority picker over five requesters: the first set
// request bit at or above ptr, wrapping 4 -> 0.
module rr_pick5
  import xbar_out_arbiter_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] winner_onehot,
  output logic [2:0] winner_idx
);

  logic [2:0] base;
  logic [3:0] cand;
  logic [2:0] idx;
  logic       hit;

  always_comb begin
    base       = (ptr > PORT_L) ? PORT_N : ptr;
    cand       = 4'd0;
    idx        = 3'd0;
    hit        = 1'b0;
    winner_idx = 3'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, base} + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      idx = cand[2:0];
      if (!hit && req[idx]) begin
        hit        = 1'b1;
        winner_idx = idx;
      end
    end
    winner_onehot = hit ? port_onehot(winner_idx) : 5'b00000;
  end

endmodule

// File: rtl/xbar_out_arbiter.sv
// Per-output wormhole arbiter: round-robin between packets, grant held from
// head to tail so flits of different packets never interleave on the output.
module xbar_out_arbiter
  import xbar_out_arbiter_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS,
  parameter int SEL_W  = PORT_SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] tail,
  input  logic              out_ready,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  output logic              locked
);

  // Handshake: a flit moves when out_valid && out_ready in the same cycle.
  // Once out_valid is shown without out_ready the grant is frozen (LOCKED) so
  // the select never changes under a flit the downstream has not taken.

  arb_state_t state_q;
  logic [2:0] owner_q;
  logic [2:0] ptr_q;

  logic [4:0] pick_onehot;
  logic [2:0] pick_idx;
  logic       xfer;

  rr_pick5 u_pick (
    .req           (req),
    .ptr           (ptr_q),
    .winner_onehot (pick_onehot),
    .winner_idx    (pick_idx)
  );

  always_comb begin
    grant     = '0;
    sel       = SEL_A;
    out_valid = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant     = pick_onehot;
            sel       = port_sel(pick_idx);
            out_valid = 1'b1;
          end
        end
        ST_LOCKED: begin
          grant     = port_onehot(owner_q);
          sel       = port_sel(owner_q);
          out_valid = req[owner_q];
        end
        default: ;
      endcase
    end
  end

  assign xfer   = out_valid & out_ready;
  assign locked = !reset && (state_q == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_N;
      ptr_q   <= PORT_N;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (out_valid) begin
            if (xfer && tail[pick_idx]) begin
              ptr_q <= port_next(pick_idx);
            end else begin
              // Multi-flit head accepted, or any flit stalled: hold this input.
              state_q <= ST_LOCKED;
              owner_q <= pick_idx;
            end
          end
        end
        ST_LOCKED: begin
          if (xfer && tail[owner_q]) begin
            state_q <= ST_IDLE;
            ptr_q   <= port_next(owner_q);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
